// File: rtl/axis_rms_level_monitor.sv
// RMS stream pass-through register slice with a debounced, hysteretic over-level alarm.
// Optional peak-hold tracker enabled by defining RMS_MONITOR_PEAK_HOLD_EN.
module axis_rms_level_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int DEB_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] th_high,
  input  logic [DATA_WIDTH-1:0] th_low,
  input  logic [DEB_WIDTH-1:0]  debounce_count,
`ifdef RMS_MONITOR_PEAK_HOLD_EN
  input  logic                  peak_clear,
  output logic [DATA_WIDTH-1:0] peak_rms,
`endif
  output logic                  alarm,
  output logic                  alarm_set,
  output logic                  alarm_clr
);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_OVR_PEND = 2'd1,
    ST_ALARM    = 2'd2,
    ST_CLR_PEND = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DEB_WIDTH-1:0]   cnt_r;
  logic [DEB_WIDTH-1:0]   cnt_nxt_s;
  logic [DEB_WIDTH-1:0]   deb_s;
  logic [DEB_WIDTH:0]     cnt_inc_s;
  logic                   deb_done_s;
  logic                   deb_one_s;
  logic                   accept_s;
  logic                   hi_s;
  logic                   lo_s;
  logic                   set_nxt_s;
  logic                   clr_nxt_s;

  assign s_axis_tready = !m_axis_tvalid | m_axis_tready;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign hi_s          = (s_axis_tdata > th_high);
  assign lo_s          = (s_axis_tdata < th_low);
  // One extra bit keeps the increment exact even if D was lowered below the running count.
  assign cnt_inc_s     = {1'b0, cnt_r} + (DEB_WIDTH+1)'(1);
  assign deb_done_s    = (cnt_inc_s >= {1'b0, deb_s});
  assign deb_one_s     = (deb_s == DEB_WIDTH'(1));

  // Effective debounce length: zero behaves as one.
  always_comb begin
    deb_s = debounce_count;
    if (debounce_count == DEB_WIDTH'(0)) begin
      deb_s = DEB_WIDTH'(1);
    end else begin
      deb_s = debounce_count;
    end
  end

  // Alarm FSM next state; only accepted samples advance it.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    set_nxt_s   = 1'b0;
    clr_nxt_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_OK: begin
          if (hi_s && deb_one_s) begin
            state_nxt_s = ST_ALARM;
            set_nxt_s   = 1'b1;
          end else if (hi_s) begin
            state_nxt_s = ST_OVR_PEND;
            cnt_nxt_s   = DEB_WIDTH'(1);
          end else begin
            state_nxt_s = ST_OK;
          end
        end
        ST_OVR_PEND: begin
          if (hi_s && deb_done_s) begin
            state_nxt_s = ST_ALARM;
            cnt_nxt_s   = DEB_WIDTH'(0);
            set_nxt_s   = 1'b1;
          end else if (hi_s) begin
            cnt_nxt_s   = cnt_inc_s[DEB_WIDTH-1:0];
          end else begin
            state_nxt_s = ST_OK;
            cnt_nxt_s   = DEB_WIDTH'(0);
          end
        end
        ST_ALARM: begin
          if (lo_s && deb_one_s) begin
            state_nxt_s = ST_OK;
            clr_nxt_s   = 1'b1;
          end else if (lo_s) begin
            state_nxt_s = ST_CLR_PEND;
            cnt_nxt_s   = DEB_WIDTH'(1);
          end else begin
            state_nxt_s = ST_ALARM;
          end
        end
        ST_CLR_PEND: begin
          if (lo_s && deb_done_s) begin
            state_nxt_s = ST_OK;
            cnt_nxt_s   = DEB_WIDTH'(0);
            clr_nxt_s   = 1'b1;
          end else if (lo_s) begin
            cnt_nxt_s   = cnt_inc_s[DEB_WIDTH-1:0];
          end else begin
            state_nxt_s = ST_ALARM;
            cnt_nxt_s   = DEB_WIDTH'(0);
          end
        end
        default: begin
          state_nxt_s = ST_OK;
          cnt_nxt_s   = DEB_WIDTH'(0);
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Slice, FSM state and alarm outputs all update on the same edge as the data.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      m_axis_tdata  <= {DATA_WIDTH{1'b0}};
      m_axis_tvalid <= 1'b0;
      state_r       <= ST_OK;
      cnt_r         <= DEB_WIDTH'(0);
      alarm         <= 1'b0;
      alarm_set     <= 1'b0;
      alarm_clr     <= 1'b0;
    end else begin
      if (accept_s) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end else begin
        m_axis_tvalid <= m_axis_tvalid;
      end
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      alarm     <= (state_nxt_s == ST_ALARM) || (state_nxt_s == ST_CLR_PEND);
      alarm_set <= set_nxt_s;
      alarm_clr <= clr_nxt_s;
    end
  end

`ifdef RMS_MONITOR_PEAK_HOLD_EN
  // Peak tracker; a clear coinciding with an accept restarts from that sample.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      peak_rms <= {DATA_WIDTH{1'b0}};
    end else if (peak_clear) begin
      peak_rms <= accept_s ? s_axis_tdata : {DATA_WIDTH{1'b0}};
    end else if (accept_s && (s_axis_tdata > peak_rms)) begin
      peak_rms <= s_axis_tdata;
    end else begin
      peak_rms <= peak_rms;
    end
  end
`else
  // Peak hold not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_rms_level_monitor.sv
// Directed self-checking bench for axis_rms_level_monitor (peak checks when RMS_MONITOR_PEAK_HOLD_EN is defined).
module tb_axis_rms_level_monitor;

  logic        aclk;
  logic        resetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] th_high;
  logic [15:0] th_low;
  logic [7:0]  debounce_count;
  logic        alarm;
  logic        alarm_set;
  logic        alarm_clr;
`ifdef RMS_MONITOR_PEAK_HOLD_EN
  logic        peak_clear;
  logic [15:0] peak_rms;
`endif

  int checks = 0;
  int errors = 0;

  axis_rms_level_monitor #(.DATA_WIDTH(16), .DEB_WIDTH(8)) dut (
    .aclk           (aclk),
    .resetn         (resetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .th_high        (th_high),
    .th_low         (th_low),
    .debounce_count (debounce_count),
`ifdef RMS_MONITOR_PEAK_HOLD_EN
    .peak_clear     (peak_clear),
    .peak_rms       (peak_rms),
`endif
    .alarm          (alarm),
    .alarm_set      (alarm_set),
    .alarm_clr      (alarm_clr)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted sample: drive, clock, sample 1 time unit after the edge.
  task automatic step(input logic [15:0] x);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = x;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic al,
                            input logic st, input logic cl);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'(d));
    chk({tag, "_alarm"},  32'(alarm),         32'(al));
    chk({tag, "_set"},    32'(alarm_set),     32'(st));
    chk({tag, "_clr"},    32'(alarm_clr),     32'(cl));
  endtask

  initial begin
    resetn         = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = 16'd0;
    m_axis_tready  = 1'b1;
    th_high        = 16'd1000;
    th_low         = 16'd800;
    debounce_count = 8'd3;
`ifdef RMS_MONITOR_PEAK_HOLD_EN
    peak_clear     = 1'b0;
`endif
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_alarm",  32'(alarm),         32'd0);
    chk("rst_set",    32'(alarm_set),     32'd0);
    chk("rst_clr",    32'(alarm_clr),     32'd0);
    chk("rst_sready", 32'(s_axis_tready), 32'd1);
    resetn = 1'b1;

    // Pass-through at full rate
    for (int i = 0; i < 4; i++) begin
      step(16'd100);
      expect_out("pass100", 16'd100, 1'b0, 1'b0, 1'b0);
    end
    idle();
    chk("pass_drain_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Interrupted over-level run does not alarm
    step(16'd1001); expect_out("intr_a", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("intr_b", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd900);  expect_out("intr_c", 16'd900,  1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("intr_d", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd500);  expect_out("intr_e", 16'd500,  1'b0, 1'b0, 1'b0);

    // Three consecutive over-level samples set the alarm
    step(16'd1001); expect_out("set_1", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("set_2", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("set_3", 16'd1001, 1'b1, 1'b1, 1'b0);
    idle();
    chk("set_hold_alarm", 32'(alarm),     32'd1);
    chk("set_pulse_end",  32'(alarm_set), 32'd0);

    // Release with hysteresis band and debounce
    step(16'd900); expect_out("clr_900", 16'd900, 1'b1, 1'b0, 1'b0);
    step(16'd799); expect_out("clr_1",   16'd799, 1'b1, 1'b0, 1'b0);
    step(16'd799); expect_out("clr_2",   16'd799, 1'b1, 1'b0, 1'b0);
    step(16'd799); expect_out("clr_3",   16'd799, 1'b0, 1'b0, 1'b1);
    idle();
    chk("clr_pulse_end", 32'(alarm_clr), 32'd0);

    // Threshold equality and debounce_count=0 acting as 1
    debounce_count = 8'd0;
    step(16'd1000); expect_out("eq_hi",  16'd1000, 1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("d0_set", 16'd1001, 1'b1, 1'b1, 1'b0);
    step(16'd800);  expect_out("eq_lo",  16'd800,  1'b1, 1'b0, 1'b0);
    step(16'd799);  expect_out("d0_clr", 16'd799,  1'b0, 1'b0, 1'b1);

    // Lowering D mid-count completes immediately
    debounce_count = 8'd3;
    step(16'd1001); expect_out("dred_1", 16'd1001, 1'b0, 1'b0, 1'b0);
    step(16'd1001); expect_out("dred_2", 16'd1001, 1'b0, 1'b0, 1'b0);
    debounce_count = 8'd2;
    step(16'd1001); expect_out("dred_3", 16'd1001, 1'b1, 1'b1, 1'b0);
    debounce_count = 8'd1;
    step(16'd0);    expect_out("dred_clr", 16'd0, 1'b0, 1'b0, 1'b1);
    debounce_count = 8'd3;
    idle();

    // Backpressure: first sample held, second waits, nothing lost or duplicated
    m_axis_tready = 1'b0;
    step(16'd11);
    chk("stall_first_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("stall_first_data",   32'(m_axis_tdata),  32'd11);
    chk("stall_sready",       32'(s_axis_tready), 32'd0);
    s_axis_tdata = 16'd22;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("stall_hold_data",   32'(m_axis_tdata),  32'd11);
      chk("stall_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("stall_hold_sready", 32'(s_axis_tready), 32'd0);
    end
    m_axis_tready = 1'b1;
    #1;
    chk("unstall_sready", 32'(s_axis_tready), 32'd1);
    @(posedge aclk); #1;
    chk("unstall_data",   32'(m_axis_tdata),  32'd22);
    chk("unstall_tvalid", 32'(m_axis_tvalid), 32'd1);
    idle();
    chk("unstall_drain", 32'(m_axis_tvalid), 32'd0);

    // Reset mid-operation discards the in-slice sample and the alarm state
    debounce_count = 8'd1;
    step(16'd2000); expect_out("pre_rst", 16'd2000, 1'b1, 1'b1, 1'b0);
    s_axis_tdata = 16'd3000;
    resetn = 1'b0;
    @(posedge aclk); #1;
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("midrst_alarm",  32'(alarm),         32'd0);
    resetn = 1'b1;
    s_axis_tvalid = 1'b0;
    debounce_count = 8'd3;
    step(16'd1001); expect_out("post_rst", 16'd1001, 1'b0, 1'b0, 1'b0);
    idle();

`ifdef RMS_MONITOR_PEAK_HOLD_EN
    peak_clear = 1'b1;
    idle();
    chk("peak_cleared", 32'(peak_rms), 32'd0);
    peak_clear = 1'b0;
    step(16'd10);
    step(16'd50);
    step(16'd20);
    chk("peak_max", 32'(peak_rms), 32'd50);
    peak_clear = 1'b1;
    step(16'd5);
    chk("peak_clear_load", 32'(peak_rms), 32'd5);
    peak_clear = 1'b0;
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
